registrador_pc: RTL and testbench
=================================

# registrador_pc

Program-counter register for the multi-cycle datapath. It holds `estado_pc` for one full instruction period of `NUM_FASES` clock cycles. At the last phase it loads either the sequential address (`endereco_soma`, from the PC adder) or a latched branch/jump target. It owns the instruction phase count and publishes it, plus per-instruction pulses, to the fetch and control logic.

## Interface
- `LARGURA`, 32: address width.
- `NUM_FASES`, 10: clock cycles per instruction; legal range is 2..16.
- `RESET_PC`, 0: value of `estado_pc` after reset.
- `clock` in 1: single clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high; takes effect only on a rising clock edge.
- `endereco_soma` in LARGURA: sequential next address (PC+1) from the adder.
- `endereco_desvio` in LARGURA: branch/jump target.
- `sel_desvio` in 1: branch request; sampled every unstalled cycle.
- `congela` in 1: stall; freezes phase, PC and pending request.
- `estado_pc` out LARGURA: current PC, registered.
- `fase` out 4: current phase, 0..NUM_FASES-1, registered.
- `nova_instrucao` out 1: one-cycle pulse, registered; high in the first cycle after a PC load.
- `desvio_tomado` out 1: one-cycle pulse, registered; high in the first cycle after a load that used the branch target.

## Operation
- State machine:
  - States are EXECUTA and CONGELADO.
  - Reset goes to EXECUTA.
  - EXECUTA→CONGELADO when `congela`=1.
  - CONGELADO→EXECUTA when `congela`=0.
  - In CONGELADO, no register changes except that both pulses go to 0.
- Phase counter:
  - In EXECUTA with `congela`=0, `fase` <= `fase`+1.
  - At `fase`=NUM_FASES-1 it wraps to 0.
  - There are no other values.
- Pending branch register, `pend` plus `alvo`:
  - Any unstalled cycle with `sel_desvio`=1 sets `pend` and captures `endereco_desvio` into `alvo`.
  - Multiple requests in one instruction: the last one wins.
- Load, on an unstalled cycle with `fase`=NUM_FASES-1:
  - If `sel_desvio`=1 in that same cycle, `estado_pc` <= `endereco_desvio` (the direct input wins over `alvo`).
  - Else if `pend`=1, `estado_pc` <= `alvo`.
  - Else `estado_pc` <= `endereco_soma`.
  - After a load, `pend` is cleared.
- Pulses:
  - `nova_instrucao` <= 1 on the load edge, 0 otherwise.
  - `desvio_tomado` <= 1 on the load edge if a branch target was used, 0 otherwise.
- Arithmetic: none on the address. Loaded values are taken verbatim with no masking or alignment, so wrap of PC+1 is the adder's responsibility.
- `congela`=1 together with the load phase: the stall wins and no load happens. The load occurs on the first unstalled cycle that is still at that phase.
- `congela`=1 together with `sel_desvio`=1: the request is ignored. The requester must hold it until it is unstalled.

## Timing
- Reset values:
  - `estado_pc`=RESET_PC
  - `fase`=0
  - `nova_instrucao`=0
  - `desvio_tomado`=0
  - `pend`=0, `alvo`=0
  - state EXECUTA
- Reset mid-instruction discards the phase and any pending branch. It has priority over `congela` and over a load.
- Without stalls, the first load after reset is on the NUM_FASES-th rising edge after the edge where `reset` is deasserted. The next loads follow every NUM_FASES edges.
- Latency from input to output:
  - `endereco_soma` and `endereco_desvio` at the load edge appear on `estado_pc` one edge later (registered).
  - The pulses are coincident with the new `estado_pc` and with `fase`=0.
- `estado_pc` is stable for exactly NUM_FASES cycles per instruction, plus any stalled cycles.
- The adder consumes `estado_pc` and must present a valid `endereco_soma` no later than the cycle with `fase`=NUM_FASES-1.

## Test plan
- Reset, then drive `endereco_soma`=1 and stay unstalled for 10 cycles:
  - `estado_pc`=0 and `fase` counts 0..9.
  - After the 10th edge, `estado_pc`=1, `fase`=0 and `nova_instrucao`=1 for exactly one cycle.
  - `desvio_tomado`=0.
- Pulse `sel_desvio`=1 with `endereco_desvio`=0x40 at `fase`=3:
  - At the next load `estado_pc`=0x40 and `desvio_tomado`=1.
  - The following instruction loads `endereco_soma` and `desvio_tomado`=0.
- Request target 0x40 at `fase`=2, then 0x80 at `fase`=9 (the load phase): `estado_pc`=0x80. Separately, two requests at `fase` 1 and 5 with 0x10 and 0x20: `estado_pc`=0x20.
- Hold `congela`=1 for 4 cycles starting at `fase`=9:
  - `fase` stays 9 and `estado_pc` does not change during the stall.
  - The load occurs on the first unstalled edge.
  - A `sel_desvio` pulse during the stall is ignored.
- Request a branch to 0x40 at `fase`=4 and assert `reset` at `fase`=6:
  - Next cycle: `estado_pc`=RESET_PC, `fase`=0, pending cleared.
  - The next load uses `endereco_soma`.
- Drive `endereco_soma`=0xFFFFFFFF into the load: `estado_pc`=0xFFFFFFFF, loaded verbatim. Also check NUM_FASES=2: loads occur every 2 cycles.

Source files
------------

// File: rtl/registrador_pc.sv
// Program-counter register for the multi-cycle datapath: holds the PC for one
// instruction period, tracks the phase and loads either PC+1 or a branch target.
module registrador_pc #(
  parameter int                   LARGURA   = 32,
  parameter int                   NUM_FASES = 10,
  parameter logic [LARGURA-1:0]   RESET_PC  = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] endereco_soma,
  input  logic [LARGURA-1:0] endereco_desvio,
  input  logic               sel_desvio,
  input  logic               congela,
  output logic [LARGURA-1:0] estado_pc,
  output logic [3:0]         fase,
  output logic               nova_instrucao,
  output logic               desvio_tomado
);

  typedef enum logic {EXECUTA, CONGELADO} estado_t;

  localparam logic [3:0] ULTIMA = 4'(NUM_FASES - 1);

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   pc_q, pc_d;
  logic [LARGURA-1:0]   alvo_q, alvo_d;
  logic [3:0]           fase_q, fase_d;
  logic                 pend_q, pend_d;
  logic                 nova_q, nova_d;
  logic                 desv_q, desv_d;
  logic                 ativo, carga;

  always_comb begin
    estado_d = estado_q;
    ativo    = 1'b0;
    case (estado_q)
      EXECUTA: begin
        if (congela) estado_d = CONGELADO;
        else         ativo    = 1'b1;
      end
      CONGELADO: begin
        // The first unstalled cycle already does work, so a load held at the
        // last phase happens on the edge that ends the stall.
        if (!congela) begin
          estado_d = EXECUTA;
          ativo    = 1'b1;
        end
      end
      default: estado_d = EXECUTA;
    endcase

    carga  = ativo && (fase_q == ULTIMA);
    pc_d   = pc_q;
    alvo_d = alvo_q;
    fase_d = fase_q;
    pend_d = pend_q;
    nova_d = carga;
    desv_d = carga && (sel_desvio || pend_q);

    if (ativo) begin
      fase_d = carga ? 4'd0 : fase_q + 4'd1;
      if (sel_desvio) begin
        pend_d = 1'b1;
        alvo_d = endereco_desvio;
      end
    end

    if (carga) begin
      pend_d = 1'b0;
      if (sel_desvio)  pc_d = endereco_desvio;
      else if (pend_q) pc_d = alvo_q;
      else             pc_d = endereco_soma;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= EXECUTA;
      pc_q     <= RESET_PC;
      alvo_q   <= '0;
      fase_q   <= 4'd0;
      pend_q   <= 1'b0;
      nova_q   <= 1'b0;
      desv_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      alvo_q   <= alvo_d;
      fase_q   <= fase_d;
      pend_q   <= pend_d;
      nova_q   <= nova_d;
      desv_q   <= desv_d;
    end
  end

  assign estado_pc      = pc_q;
  assign fase           = fase_q;
  assign nova_instrucao = nova_q;
  assign desvio_tomado  = desv_q;

endmodule

// File: tb/tb_registrador_pc.sv
// Scoreboard bench for registrador_pc: a behavioural model pushes the expected
// outputs of a 10-phase and a 2-phase instance each cycle; they are popped after the edge.
module tb_registrador_pc;

  logic        clock = 1'b0;
  logic        reset, sel_desvio, congela;
  logic [31:0] endereco_soma, endereco_soma2, endereco_desvio;
  logic [31:0] estado_pc, estado_pc2;
  logic [3:0]  fase, fase2;
  logic        nova_instrucao, nova_instrucao2, desvio_tomado, desvio_tomado2;

  always #5 clock = ~clock;

  registrador_pc #(.LARGURA(32), .NUM_FASES(10), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .endereco_soma(endereco_soma),
    .endereco_desvio(endereco_desvio), .sel_desvio(sel_desvio), .congela(congela),
    .estado_pc(estado_pc), .fase(fase), .nova_instrucao(nova_instrucao),
    .desvio_tomado(desvio_tomado));

  registrador_pc #(.LARGURA(32), .NUM_FASES(2), .RESET_PC(32'h0)) dut2 (
    .clock(clock), .reset(reset), .endereco_soma(endereco_soma2),
    .endereco_desvio(endereco_desvio), .sel_desvio(sel_desvio), .congela(congela),
    .estado_pc(estado_pc2), .fase(fase2), .nova_instrucao(nova_instrucao2),
    .desvio_tomado(desvio_tomado2));

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  fase;
    logic        nova, desv, pend;
    logic [31:0] alvo;
  } mst_t;

  typedef struct {
    mst_t a;
    mst_t b;
  } exp_t;

  mst_t        ma, mb;
  exp_t        fila[$];
  int          n_tot = 0, n_pass = 0;
  logic        soma_fixa = 1'b0;
  logic [31:0] soma_val = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic mst_t passo(input mst_t s, input int nf, input logic rst,
                                 input logic sel, input logic cong,
                                 input logic [31:0] soma, input logic [31:0] desvio);
    mst_t n = s;
    logic load;
    if (rst) begin
      n.pc = 0; n.fase = 0; n.nova = 0; n.desv = 0; n.pend = 0; n.alvo = 0;
    end else if (cong) begin
      n.nova = 0; n.desv = 0;
    end else begin
      load   = (int'(s.fase) == nf - 1);
      n.nova = load;
      n.desv = load && (sel || s.pend);
      n.fase = load ? 4'd0 : s.fase + 4'd1;
      if (load) begin
        n.pc   = sel ? desvio : (s.pend ? s.alvo : soma);
        n.pend = 0;
      end else if (sel) begin
        n.pend = 1; n.alvo = desvio;
      end
    end
    return n;
  endfunction

  task automatic ciclo();
    exp_t e;
    endereco_soma  = soma_fixa ? soma_val : ma.pc + 32'd1;
    endereco_soma2 = mb.pc + 32'd1;
    ma = passo(ma, 10, reset, sel_desvio, congela, endereco_soma, endereco_desvio);
    mb = passo(mb, 2, reset, sel_desvio, congela, endereco_soma2, endereco_desvio);
    fila.push_back('{ma, mb});
    @(posedge clock);
    #1;
    e = fila.pop_front();
    check("pc",    estado_pc,       e.a.pc);
    check("fase",  fase,            e.a.fase);
    check("nova",  nova_instrucao,  e.a.nova);
    check("desv",  desvio_tomado,   e.a.desv);
    check("pc2",   estado_pc2,      e.b.pc);
    check("fase2", fase2,           e.b.fase);
    check("nova2", nova_instrucao2, e.b.nova);
    check("desv2", desvio_tomado2,  e.b.desv);
  endtask

  // Advance (bounded) until the modelled 10-phase instance sits at phase f.
  task automatic ir_fase(input int f);
    for (int i = 0; i < 20 && int'(ma.fase) != f; i++) ciclo();
  endtask

  task automatic pulso_desvio(input logic [31:0] alvo);
    sel_desvio = 1'b1; endereco_desvio = alvo;
    ciclo();
    sel_desvio = 1'b0;
  endtask

  initial begin
    logic [31:0] pc0;
    int cargas;
    ma = '{default: '0}; mb = '{default: '0};
    reset = 1'b1; sel_desvio = 1'b0; congela = 1'b0;
    endereco_desvio = '0; endereco_soma = '0; endereco_soma2 = '0;
    @(negedge clock);
    ciclo(); ciclo();
    check("rst_pc", estado_pc, 32'h0);
    check("rst_fase", fase, 4'd0);
    check("rst_nova", nova_instrucao, 1'b0);
    reset = 1'b0;

    // Plain sequential instruction.
    repeat (10) ciclo();
    check("seq_pc", estado_pc, 32'h1);
    check("seq_nova", nova_instrucao, 1'b1);
    check("seq_desv", desvio_tomado, 1'b0);
    ciclo();
    check("seq_nova_pulso", nova_instrucao, 1'b0);

    // Branch requested mid-instruction, taken at the next load.
    ir_fase(3); pulso_desvio(32'h40);
    ir_fase(9); ciclo();
    check("br_pc", estado_pc, 32'h40);
    check("br_desv", desvio_tomado, 1'b1);
    ir_fase(9); ciclo();
    check("br_seq_pc", estado_pc, 32'h41);
    check("br_seq_desv", desvio_tomado, 1'b0);

    // Last request wins; direct input at the load phase wins over the latch.
    ir_fase(2); pulso_desvio(32'h40);
    ir_fase(9); pulso_desvio(32'h80);
    check("dir_pc", estado_pc, 32'h80);
    ir_fase(1); pulso_desvio(32'h10);
    ir_fase(5); pulso_desvio(32'h20);
    ir_fase(9); ciclo();
    check("ult_pc", estado_pc, 32'h20);

    // Stall across the load phase with an ignored request inside it.
    ir_fase(9); pc0 = ma.pc;
    congela = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel_desvio = (i == 1); endereco_desvio = 32'h99;
      ciclo();
      check("stall_fase", fase, 4'd9);
      check("stall_pc", estado_pc, pc0);
    end
    congela = 1'b0; sel_desvio = 1'b0;
    ciclo();
    check("stall_load_pc", estado_pc, pc0 + 32'd1);
    check("stall_load_desv", desvio_tomado, 1'b0);

    // Reset mid-instruction discards the pending branch.
    ir_fase(4); pulso_desvio(32'h40);
    ir_fase(6); reset = 1'b1; ciclo(); reset = 1'b0;
    check("rmid_pc", estado_pc, 32'h0);
    check("rmid_fase", fase, 4'd0);
    ir_fase(9); ciclo();
    check("rmid_load_pc", estado_pc, 32'h1);
    check("rmid_load_desv", desvio_tomado, 1'b0);

    // All-ones address is loaded verbatim.
    ir_fase(9); soma_fixa = 1'b1; soma_val = 32'hFFFF_FFFF;
    ciclo(); soma_fixa = 1'b0;
    check("max_pc", estado_pc, 32'hFFFF_FFFF);

    // Two-phase instance loads every other edge.
    cargas = 0;
    for (int i = 0; i < 8; i++) begin
      ciclo();
      if (nova_instrucao2) cargas++;
    end
    check("nf2_cargas", cargas, 4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
